// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target front end: FSM states, bus
// acknowledge levels and the default device address.
`timescale 1ns/1ps
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

    localparam logic       I2C_ACK                = 1'b0;
    localparam logic       I2C_NACK               = 1'b1;
    localparam logic       I2C_WRITE              = 1'b0;
    localparam logic [6:0] DEFAULT_TARGET_ADDRESS = 7'h40;
    localparam logic [3:0] BITS_PER_BYTE          = 4'd8;

    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] target);
        return addr_byte[7:1] == target;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk_i and derives bit-clock edges plus
// START/STOP conditions from the synchronized samples.
`timescale 1ns/1ps
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    // Fewer than two stages would not be a synchronizer at all.
    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [STAGES-1:0] sda_sync_q, sda_sync_d;
    logic              scl_hist_q, scl_hist_d;
    logic              sda_hist_q, sda_hist_d;
    logic              scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[STAGES-2:0], sda_i};
        scl_hist_d = scl_sync_q[STAGES-1];
        sda_hist_d = sda_sync_q[STAGES-1];
    end

    // An idle bus is pulled high, so everything resets to 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    assign scl_s     = scl_sync_q[STAGES-1];
    assign sda_s     = sda_sync_q[STAGES-1];
    assign scl_rise  =  scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s &  scl_hist_q;
    assign start_det =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target front end: decodes the device address, maintains the register
// pointer, strobes writes/reads to the register file and returns read data.
`timescale 1ns/1ps
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDRESS = DEFAULT_TARGET_ADDRESS,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    inout  wire        sda_io,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    input  logic [7:0] reg_rdata_i,
    output logic       reg_re_o,
    output logic       busy_o
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .scl_i    (scl_i),
        .sda_i    (sda_io),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       sda_drive_q, sda_drive_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       busy_q, busy_d;
    logic       rd_load_q, rd_load_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        sda_drive_d = sda_drive_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        busy_d      = busy_q;
        rd_load_d   = 1'b0;

        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            sda_drive_d = 1'b0;
            busy_d      = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            sda_drive_d = 1'b0;
            busy_d      = 1'b0;
        end else if (rd_load_q) begin
            // Pointer advanced last cycle, so reg_rdata_i now reflects the next byte.
            reg_re_d    = 1'b1;
            shift_d     = reg_rdata_i;
            sda_drive_d = ~reg_rdata_i[7];
            bit_cnt_d   = 4'd1;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q < BITS_PER_BYTE) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == ST_WDATA && bit_cnt_q == BITS_PER_BYTE - 4'd1) begin
                            reg_wdata_d = {shift_q[6:0], sda_s};
                            reg_we_d    = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                        sda_drive_d = 1'b1;
                        case (state_q)
                            ST_ADDR: begin
                                if (addr_match(shift_q, TARGET_ADDRESS)) begin
                                    state_d = ST_ADDR_ACK;
                                    busy_d  = 1'b1;
                                    rw_d    = shift_q[0];
                                end else begin
                                    state_d     = ST_IGNORE;
                                    sda_drive_d = 1'b0;
                                end
                            end
                            ST_REG: begin
                                reg_addr_d = shift_q;
                                state_d    = ST_REG_ACK;
                            end
                            default: state_d = ST_WDATA_ACK;
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q == I2C_WRITE) begin
                            sda_drive_d = 1'b0;
                            bit_cnt_d   = '0;
                            state_d     = ST_REG;
                        end else begin
                            reg_re_d    = 1'b1;
                            shift_d     = reg_rdata_i;
                            sda_drive_d = ~reg_rdata_i[7];
                            bit_cnt_d   = 4'd1;
                            state_d     = ST_RDATA;
                        end
                    end
                end
                ST_REG_ACK: begin
                    if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        bit_cnt_d   = '0;
                        state_d     = ST_WDATA;
                    end
                end
                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_drive_d = 1'b0;
                        bit_cnt_d   = '0;
                        reg_addr_d  = reg_addr_q + 8'd1;
                        state_d     = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == BITS_PER_BYTE) begin
                            sda_drive_d = 1'b0;
                            state_d     = ST_RDATA_ACK;
                        end else begin
                            sda_drive_d = ~shift_q[6];
                            shift_d     = {shift_q[6:0], 1'b0};
                            bit_cnt_d   = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise && sda_s == I2C_NACK) begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                    end else if (scl_fall) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        rd_load_d  = 1'b1;
                        state_d    = ST_RDATA;
                    end
                end
                default: begin
                    sda_drive_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            sda_drive_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            rd_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            sda_drive_q <= sda_drive_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
            rd_load_q   <= rd_load_d;
        end
    end

    // Open drain: only ever pull low or let go.
    assign sda_io      = sda_drive_q ? 1'b0 : 1'bz;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bus-master bench for i2c_target: drives I2C transactions, models the
// register file and pointer, and scoreboards every register strobe.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int         Q     = 6;       // clk cycles per quarter SCL period
    localparam logic [6:0] TADDR = 7'h40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl   = 1'b1;
    logic m_drv = 1'b0;
    wire  sda_bus;

    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    assign sda_bus = m_drv ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_target #(
        .TARGET_ADDRESS(TADDR),
        .SYNC_STAGES   (2)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl),
        .sda_io     (sda_bus),
        .reg_addr_o (reg_addr),
        .reg_wdata_o(reg_wdata),
        .reg_we_o   (reg_we),
        .reg_rdata_i(reg_rdata),
        .reg_re_o   (reg_re),
        .busy_o     (busy)
    );

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rf     [256];   // register file seen by the DUT
    logic [7:0] m_regs [256];   // reference copy
    logic [7:0] m_ptr;
    logic [7:0] tx_d[$];
    bit         rf_ready   = 1'b0;
    bit         quiet_mode = 1'b0;
    bit         quiet_viol = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    assign reg_rdata = rf[reg_addr];

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 73 + 29) ^ (i >> 2));
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: register file behaviour, strobe scoreboard, idle-bus watch.
    always @(negedge clk) begin
        if (!rf_ready) begin
            for (int i = 0; i < 256; i++) rf[i] <= init_val(i);
            rf_ready <= 1'b1;
        end
        if (reg_we || reg_re) begin
            if (exp_q.size() == 0) begin
                check(reg_we ? "unexpected write strobe" : "unexpected read strobe", 1, 0);
            end else begin
                check("strobe kind (1=write)", int'(reg_we), int'(exp_q[0].is_wr));
                check("strobe address", reg_addr, exp_q[0].addr);
                if (exp_q[0].is_wr) check("strobe write data", reg_wdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (reg_we) rf[reg_addr] <= reg_wdata;
        end
        if (!quiet_mode)
            quiet_viol <= 1'b0;
        else if (sda_bus === 1'b0 && !m_drv)
            quiet_viol <= 1'b1;
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_drv = 1'b0; wq(Q);
        scl   = 1'b1; wq(Q);
        m_drv = 1'b1; wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic bus_stop();
        m_drv = 1'b1; wq(Q);
        scl   = 1'b1; wq(Q);
        m_drv = 1'b0; wq(2 * Q);
    endtask

    task automatic bus_bit(input bit b, output bit r);
        m_drv = ~b;   wq(Q);
        scl   = 1'b1; wq(Q);
        r     = sda_bus;
        wq(Q);
        scl   = 1'b0; wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output bit ack);
        bit r;
        for (int i = 7; i >= 0; i--) bus_bit(v[i], r);
        bus_bit(1'b1, ack);
    endtask

    // Write transaction: address, pointer byte, then tx_d data bytes, STOP.
    task automatic write_txn(input logic [6:0] a, input logic [7:0] ptr);
        bit ack;
        bit hit;
        hit = (a == TADDR);
        bus_start();
        send_byte({a, 1'b0}, ack);
        check("address ack", ack, hit ? 0 : 1);
        check("busy after address", busy, hit ? 1 : 0);
        send_byte(ptr, ack);
        check("pointer byte ack", ack, hit ? 0 : 1);
        if (hit) m_ptr = ptr;
        foreach (tx_d[i]) begin
            if (hit) exp_q.push_back('{is_wr: 1'b1, addr: m_ptr, data: tx_d[i]});
            send_byte(tx_d[i], ack);
            check("data byte ack", ack, hit ? 0 : 1);
            if (hit) begin
                m_regs[m_ptr] = tx_d[i];
                m_ptr++;
            end
        end
        bus_stop();
        check("busy after stop", busy, 0);
        check("pointer after write", reg_addr, m_ptr);
        $display("txn write addr=0x%02h ptr=0x%02h bytes=%0d next_ptr=0x%02h",
                 a, ptr, tx_d.size(), m_ptr);
    endtask

    // Pointer write, repeated START, read n bytes, NACK the last one, STOP.
    task automatic read_txn(input logic [7:0] ptr, input int n);
        bit         ack, r;
        logic [7:0] v;
        bus_start();
        send_byte({TADDR, 1'b0}, ack);
        check("read: write address ack", ack, 0);
        send_byte(ptr, ack);
        check("read: pointer ack", ack, 0);
        m_ptr = ptr;
        bus_start();
        exp_q.push_back('{is_wr: 1'b0, addr: m_ptr, data: 8'h00});
        send_byte({TADDR, 1'b1}, ack);
        check("read: read address ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                bus_bit(1'b1, r);
                v[b] = r;
            end
            check("read data byte", v, m_regs[m_ptr]);
            if (i < n - 1) begin
                m_ptr++;
                exp_q.push_back('{is_wr: 1'b0, addr: m_ptr, data: 8'h00});
                bus_bit(1'b0, r);
            end else begin
                bus_bit(1'b1, r);
                check("sda released in master ack slot", r, 1);
                check("busy after master nack", busy, 0);
            end
        end
        bus_stop();
        check("pointer after read", reg_addr, m_ptr);
        $display("txn read ptr=0x%02h bytes=%0d last_byte=0x%02h", ptr, n, v);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ack, r;
        logic [6:0] fa;
        logic [7:0] p;
        int         kind, n;

        for (int i = 0; i < 256; i++) m_regs[i] = init_val(i);
        m_ptr = 8'h00;

        wq(5);
        check("reset: sda released", sda_bus, 1);
        check("reset: reg_addr", reg_addr, 0);
        check("reset: reg_wdata", reg_wdata, 0);
        check("reset: reg_we", reg_we, 0);
        check("reset: reg_re", reg_re, 0);
        check("reset: busy", busy, 0);
        rst_n = 1'b1;
        wq(4 * Q);

        tx_d = '{8'h21};
        write_txn(TADDR, 8'h00);

        tx_d = '{8'h11, 8'h22, 8'h33};
        write_txn(TADDR, 8'hFE);

        quiet_mode = 1'b1;
        tx_d = '{8'h5A};
        write_txn(7'h41, 8'h07);
        check("foreign address: sda never pulled", quiet_viol, 0);
        quiet_mode = 1'b0;

        tx_d = '{8'hA5};
        write_txn(TADDR, 8'h06);
        read_txn(8'h06, 1);

        // STOP after four data bits: no strobe, pointer kept.
        bus_start();
        send_byte({TADDR, 1'b0}, ack);
        check("abort: address ack", ack, 0);
        send_byte(8'h10, ack);
        check("abort: pointer ack", ack, 0);
        m_ptr = 8'h10;
        for (int i = 0; i < 4; i++) bus_bit(i[0], r);
        bus_stop();
        check("abort: busy", busy, 0);
        check("abort: sda released", sda_bus, 1);
        check("abort: pointer", reg_addr, m_ptr);
        $display("txn aborted write ptr=0x10 after 4 bits");
        tx_d = '{8'h3C};
        write_txn(TADDR, 8'h10);

        for (int it = 0; it < 12; it++) begin
            kind = int'($urandom_range(0, 2));
            n    = int'($urandom_range(1, 3));
            p    = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) p = 8'hFD;
            if (kind == 0) begin
                tx_d.delete();
                for (int i = 0; i < n; i++) tx_d.push_back(8'($urandom_range(0, 255)));
                write_txn(TADDR, p);
            end else if (kind == 1) begin
                read_txn(p, n);
            end else begin
                fa = 7'($urandom_range(0, 127));
                if (fa == TADDR) fa = fa ^ 7'h01;
                tx_d = '{8'($urandom_range(0, 255))};
                quiet_mode = 1'b1;
                write_txn(fa, p);
                check("foreign address: sda never pulled", quiet_viol, 0);
                quiet_mode = 1'b0;
            end
        end

        // Reset while the target is pulling SDA low for the address ACK.
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(TADDR[i > 0 ? i - 1 : 0] & (i > 0), r);
        m_drv = 1'b0;
        wq(2);
        check("target drives address ack", sda_bus, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset mid-ack: sda released", sda_bus, 1);
        check("reset mid-ack: reg_addr", reg_addr, 0);
        check("reset mid-ack: reg_wdata", reg_wdata, 0);
        check("reset mid-ack: reg_we", reg_we, 0);
        check("reset mid-ack: reg_re", reg_re, 0);
        check("reset mid-ack: busy", busy, 0);
        $display("txn reset asserted during address ack");
        wq(4);
        rst_n = 1'b1;
        m_ptr = 8'h00;
        scl   = 1'b1;
        wq(4 * Q);
        tx_d = '{8'h77};
        write_txn(TADDR, 8'h02);

        wq(4 * Q);
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
